// File: rtl/dot_product_seq_ctrl.sv
// dot_product_seq_ctrl
//   Sequencer and result collector for the 4-lane 8x8 signed dot-product
//   datapath. It accepts a length command and streams operand beats into the
//   datapath with first/last framing. Non-handshake cycles feed zero operands.
//   Results are collected in a credit-protected first-word-fall-through FIFO.
//
// Ports
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_cmd_len/valid, o_cmd_ready  vector length command (beats)
//   i_op_a/b/valid, o_op_ready    operand beat stream
//   o_dp_a/b/first/last       registered drive to the datapath
//   i_dp_sum/valid            datapath result
//   o_res_sum/valid, i_res_ready  result FIFO head
//   o_busy                    streaming, or results still owed
//   o_err_overflow            sticky: result arrived with the FIFO full and no pop
module dot_product_seq_ctrl #(
    parameter int unsigned N         = 8,
    parameter int unsigned M         = 4,
    parameter int unsigned S         = 48,
    parameter int unsigned LEN_W     = 12,
    parameter int unsigned RES_DEPTH = 4,
    parameter int unsigned LATENCY   = 6
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [LEN_W-1:0] i_cmd_len,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [M*N-1:0]   i_op_a,
    input  logic [M*N-1:0]   i_op_b,
    input  logic             i_op_valid,
    output logic             o_op_ready,
    output logic [M*N-1:0]   o_dp_a,
    output logic [M*N-1:0]   o_dp_b,
    output logic             o_dp_first,
    output logic             o_dp_last,
    input  logic [S-1:0]     i_dp_sum,
    input  logic             i_dp_valid,
    output logic [S-1:0]     o_res_sum,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic             o_busy,
    output logic             o_err_overflow
);

    localparam int unsigned CW = $clog2(RES_DEPTH + 1);
    localparam int unsigned PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int unsigned DW = $clog2(LATENCY + 2);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t           state, state_nx;
    logic [LEN_W-1:0] remaining, remaining_nx;
    logic             first_pending, first_pending_nx;
    logic [CW-1:0]    reserved;
    logic [DW-1:0]    drain;

    logic [S-1:0]     fifo_mem [RES_DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count;

    logic draining, fifo_full, fifo_empty;
    logic cmd_take, op_hs, push, pop, push_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RES_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign draining   = (drain != '0);
    assign fifo_full  = (count == CW'(RES_DEPTH));
    assign fifo_empty = (count == '0);

    assign op_hs   = (state == STREAM) && i_op_valid;
    // Results still in flight from an aborted vector are dropped until the
    // drain counter expires.
    assign push    = i_dp_valid && !draining;
    assign pop     = !fifo_empty && i_res_ready;
    assign push_ok = push && (!fifo_full || pop);

    assign o_res_valid = !fifo_empty;
    assign o_res_sum   = fifo_empty ? '0 : fifo_mem[rd_ptr];
    assign o_busy      = (state == STREAM) || (reserved != '0);

    always_comb begin
        state_nx         = state;
        remaining_nx     = remaining;
        first_pending_nx = first_pending;
        o_cmd_ready      = 1'b0;
        o_op_ready       = 1'b0;
        cmd_take         = 1'b0;
        case (state)
            IDLE: begin
                o_cmd_ready = !draining && (reserved < CW'(RES_DEPTH));
                // A zero-length command is consumed without taking a credit.
                if (o_cmd_ready && i_cmd_valid && (i_cmd_len != '0)) begin
                    remaining_nx     = i_cmd_len;
                    first_pending_nx = 1'b1;
                    cmd_take         = 1'b1;
                    state_nx         = STREAM;
                end
            end
            STREAM: begin
                o_op_ready = 1'b1;
                if (i_op_valid) begin
                    remaining_nx     = remaining - 1'b1;
                    first_pending_nx = 1'b0;
                    if (remaining == LEN_W'(1)) state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state          <= IDLE;
            remaining      <= '0;
            first_pending  <= 1'b0;
            reserved       <= '0;
            drain          <= DW'(LATENCY + 1);
            o_dp_a         <= '0;
            o_dp_b         <= '0;
            o_dp_first     <= 1'b0;
            o_dp_last      <= 1'b0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            o_err_overflow <= 1'b0;
        end else begin
            state         <= state_nx;
            remaining     <= remaining_nx;
            first_pending <= first_pending_nx;

            if (draining) drain <= drain - 1'b1;

            // The datapath accumulates every cycle, so idle cycles carry zeros.
            if (op_hs) begin
                o_dp_a     <= i_op_a;
                o_dp_b     <= i_op_b;
                o_dp_first <= first_pending;
                o_dp_last  <= (remaining == LEN_W'(1));
            end else begin
                o_dp_a     <= '0;
                o_dp_b     <= '0;
                o_dp_first <= 1'b0;
                o_dp_last  <= 1'b0;
            end

            case ({cmd_take, pop})
                2'b10:   reserved <= reserved + 1'b1;
                2'b01:   reserved <= reserved - 1'b1;
                default: reserved <= reserved;
            endcase

            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)     rd_ptr <= ptr_inc(rd_ptr);
            if (push_ok && !pop)      count <= count + 1'b1;
            else if (!push_ok && pop) count <= count - 1'b1;

            if (push && fifo_full && !pop) o_err_overflow <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset && push_ok) fifo_mem[wr_ptr] <= i_dp_sum;
    end

    a_no_credit_underflow: assert property (@(posedge i_clk) disable iff (i_reset)
        pop |-> (reserved != '0));
    a_no_credit_overflow: assert property (@(posedge i_clk) disable iff (i_reset)
        reserved <= CW'(RES_DEPTH));

endmodule

// File: tb/tb_dot_product_seq_ctrl.sv
// tb_dot_product_seq_ctrl
//   Drives dot_product_seq_ctrl against a behavioural model of the datapath
//   and checks framing, results (via an in-order queue), credits, reset abort
//   and overflow behaviour.
module tb_dot_product_seq_ctrl;

    localparam int LAT = 6;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [11:0] i_cmd_len = '0;
    logic        i_cmd_valid = 1'b0;
    logic        o_cmd_ready;
    logic [31:0] i_op_a = '0, i_op_b = '0;
    logic        i_op_valid = 1'b0;
    logic        o_op_ready;
    logic [31:0] o_dp_a, o_dp_b;
    logic        o_dp_first, o_dp_last;
    logic [47:0] i_dp_sum;
    logic        i_dp_valid;
    logic [47:0] o_res_sum;
    logic        o_res_valid;
    logic        i_res_ready = 1'b0;
    logic        o_busy, o_err_overflow;

    always #5 clk = ~clk;

    dot_product_seq_ctrl #(
        .N(8), .M(4), .S(48), .LEN_W(12), .RES_DEPTH(4), .LATENCY(LAT)
    ) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_cmd_len(i_cmd_len), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_op_a(i_op_a), .i_op_b(i_op_b), .i_op_valid(i_op_valid), .o_op_ready(o_op_ready),
        .o_dp_a(o_dp_a), .o_dp_b(o_dp_b), .o_dp_first(o_dp_first), .o_dp_last(o_dp_last),
        .i_dp_sum(i_dp_sum), .i_dp_valid(i_dp_valid),
        .o_res_sum(o_res_sum), .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
        .o_busy(o_busy), .o_err_overflow(o_err_overflow)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_hs_cyc = 0;
    longint sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- datapath model: sampled beat -> valid LAT cycles later
    logic   force_v = 1'b0;
    longint force_s = 0;
    logic   pv [0:LAT];
    longint ps [0:LAT];
    longint acc;

    always @(posedge clk) begin
        longint prod, nacc;
        if (i_reset) begin
            acc <= 0;
            for (int j = 0; j <= LAT; j++) begin
                pv[j] <= 1'b0;
                ps[j] <= 0;
            end
        end else begin
            prod = 0;
            for (int i = 0; i < 4; i++)
                prod += longint'($signed(o_dp_a[i*8 +: 8])) * longint'($signed(o_dp_b[i*8 +: 8]));
            nacc = o_dp_first ? prod : acc + prod;
            acc <= nacc;
            for (int j = LAT; j > 0; j--) begin
                pv[j] <= pv[j-1];
                ps[j] <= ps[j-1];
            end
            pv[0] <= o_dp_last;
            ps[0] <= nacc;
        end
    end

    assign i_dp_valid = force_v | pv[LAT];
    assign i_dp_sum   = force_v ? 48'(force_s) : 48'(ps[LAT]);

    // ---------------- monitor: scoreboard pops and zero-beat counting
    logic in_vec = 1'b0;
    int   zcnt = 0;
    int   last_zero = -1;

    always @(negedge clk) begin
        if (!i_reset) begin
            if (o_res_valid && i_res_ready) begin
                if (sb.size() == 0) chk("unexpected_result", 1, 0);
                else chk("result_sum", $signed(o_res_sum), sb.pop_front());
            end
            if (o_dp_first) begin
                in_vec = 1'b1;
                zcnt   = 0;
            end else if (in_vec && !o_dp_last && o_dp_a == '0 && o_dp_b == '0) begin
                zcnt++;
            end
            if (o_dp_last) begin
                in_vec    = 1'b0;
                last_zero = zcnt;
            end
        end
    end

    // ---------------- stimulus helpers (all start and end at posedge+1)
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input int len);
        int n = 0;
        i_cmd_valid = 1'b1;
        i_cmd_len   = 12'(len);
        while (!o_cmd_ready && n < 200) begin tick(); n++; end
        chk("cmd_wait_timeout", longint'(n >= 200), 0);
        tick();
        i_cmd_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] a, input logic [31:0] b,
                             input logic f, input logic l);
        int n = 0;
        i_op_valid = 1'b1;
        i_op_a = a;
        i_op_b = b;
        while (!o_op_ready && n < 200) begin tick(); n++; end
        chk("op_wait_timeout", longint'(n >= 200), 0);
        tick();
        last_hs_cyc = cyc;
        i_op_valid = 1'b0;
        i_op_a = '0;
        i_op_b = '0;
        chk("dp_a", o_dp_a, a);
        chk("dp_b", o_dp_b, b);
        chk("dp_first", o_dp_first, f);
        chk("dp_last", o_dp_last, l);
    endtask

    task automatic wait_empty();
        int n = 0;
        while ((sb.size() != 0 || o_res_valid) && n < 300) begin tick(); n++; end
        chk("drain_timeout", longint'(n >= 300), 0);
    endtask

    function automatic logic [31:0] pk(input int l0, input int l1, input int l2, input int l3);
        return {l3[7:0], l2[7:0], l1[7:0], l0[7:0]};
    endfunction

    typedef struct {
        int          len;
        int          stall;
        logic [31:0] a [4];
        logic [31:0] b [4];
        longint      exp;
    } vec_t;

    function automatic vec_t mk(input int len, input int stall,
                                input logic [31:0] a0, input logic [31:0] b0,
                                input logic [31:0] a1, input logic [31:0] b1,
                                input logic [31:0] a2, input logic [31:0] b2,
                                input logic [31:0] a3, input logic [31:0] b3,
                                input longint exp);
        vec_t v;
        v.len = len; v.stall = stall; v.exp = exp;
        v.a[0] = a0; v.b[0] = b0; v.a[1] = a1; v.b[1] = b1;
        v.a[2] = a2; v.b[2] = b2; v.a[3] = a3; v.b[3] = b3;
        return v;
    endfunction

    vec_t tbl [7];

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, o_cmd_ready, 0);
        chk({tag, "_op_ready"}, o_op_ready, 0);
        chk({tag, "_dp_a"}, o_dp_a, 0);
        chk({tag, "_dp_first"}, o_dp_first, 0);
        chk({tag, "_dp_last"}, o_dp_last, 0);
        chk({tag, "_res_valid"}, o_res_valid, 0);
        chk({tag, "_res_sum"}, o_res_sum, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_err"}, o_err_overflow, 0);
    endtask

    initial begin
        int bad;
        tbl[0] = mk(2, 0, pk(1,2,3,4), pk(1,1,1,1), pk(-1,-1,-1,-1), pk(2,2,2,2), 0, 0, 0, 0, 2);
        tbl[1] = mk(1, 0, pk(127,127,127,127), pk(127,127,127,127), 0, 0, 0, 0, 0, 0, 64516);
        tbl[2] = mk(1, 0, pk(-128,-128,-128,-128), pk(-128,-128,-128,-128), 0, 0, 0, 0, 0, 0, 65536);
        tbl[3] = mk(1, 0, pk(-128,127,0,5), pk(127,-128,9,-3), 0, 0, 0, 0, 0, 0, -32527);
        tbl[4] = mk(3, 5, pk(1,1,1,1), pk(1,2,3,4), pk(2,2,2,2), pk(-1,-1,-1,-1),
                    pk(10,0,0,0), pk(10,0,0,0), 0, 0, 102);
        tbl[5] = mk(3, 0, pk(1,1,1,1), pk(1,2,3,4), pk(2,2,2,2), pk(-1,-1,-1,-1),
                    pk(10,0,0,0), pk(10,0,0,0), 0, 0, 102);
        tbl[6] = mk(4, 0, pk(1,2,3,4), pk(5,6,7,8), pk(1,2,3,4), pk(5,6,7,8),
                    pk(1,2,3,4), pk(5,6,7,8), pk(1,2,3,4), pk(5,6,7,8), 280);

        // ---- reset state and drain window
        i_reset = 1'b1;
        repeat (3) tick();
        check_reset_outputs("reset");
        i_reset = 1'b0;
        repeat (LAT) tick();
        chk("drain_cmd_ready_low", o_cmd_ready, 0);
        tick();
        chk("drain_cmd_ready_high", o_cmd_ready, 1);

        // ---- table-driven vectors, results in order
        i_res_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            sb.push_back(tbl[i].exp);
            send_cmd(tbl[i].len);
            for (int k = 0; k < tbl[i].len; k++) begin
                if (k == 1) repeat (tbl[i].stall) tick();
                send_beat(tbl[i].a[k], tbl[i].b[k], k == 0, k == tbl[i].len - 1);
            end
            tick();
            chk("zero_beats_in_vector", last_zero, tbl[i].stall);
            if (i == 0) begin
                int n = 0;
                while (!o_res_valid && n < 50) begin tick(); n++; end
                chk("result_latency", cyc - last_hs_cyc, LAT + 2);
            end
        end
        wait_empty();
        chk("idle_busy", o_busy, 0);

        // ---- credit backpressure
        i_res_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            sb.push_back(k);
            send_cmd(1);
            send_beat(pk(k,0,0,0), pk(1,0,0,0), 1'b1, 1'b1);
        end
        i_cmd_valid = 1'b1;
        i_cmd_len   = 12'd1;
        bad = 0;
        repeat (20) begin tick(); if (o_cmd_ready) bad++; end
        chk("credit_block", bad, 0);
        chk("credit_busy", o_busy, 1);
        i_res_ready = 1'b1;
        tick();
        i_res_ready = 1'b0;
        sb.push_back(5);
        chk("credit_freed", o_cmd_ready, 1);
        tick();
        i_cmd_valid = 1'b0;
        chk("fifth_accepted", o_op_ready, 1);
        send_beat(pk(5,0,0,0), pk(1,0,0,0), 1'b1, 1'b1);
        repeat (LAT + 4) tick();
        i_res_ready = 1'b1;
        wait_empty();

        // ---- zero-length command then length 1
        send_cmd(0);
        chk("len0_no_stream", o_op_ready, 0);
        chk("len0_no_busy", o_busy, 0);
        sb.push_back(7);
        send_cmd(1);
        send_beat(pk(7,0,0,0), pk(1,0,0,0), 1'b1, 1'b1);
        wait_empty();
        repeat (LAT + 4) tick();
        chk("len0_no_extra", o_res_valid, 0);
        chk("len0_busy_falls", o_busy, 0);

        // ---- reset on beat 2 of a length-4 vector
        send_cmd(4);
        send_beat(pk(3,3,3,3), pk(3,3,3,3), 1'b1, 1'b0);
        i_op_valid = 1'b1;
        i_op_a = pk(9,9,9,9);
        i_op_b = pk(9,9,9,9);
        i_reset = 1'b1;
        tick();
        i_op_valid = 1'b0;
        i_op_a = '0;
        i_op_b = '0;
        check_reset_outputs("abort");
        i_reset = 1'b0;
        force_v = 1'b1;
        force_s = 999;
        bad = 0;
        for (int k = 0; k < LAT + 1; k++) begin
            tick();
            if (o_res_valid) bad++;
            if (k < LAT && o_cmd_ready) bad++;
        end
        force_v = 1'b0;
        chk("abort_stale_ignored", bad, 0);
        tick();
        chk("abort_no_result", o_res_valid, 0);
        chk("abort_cmd_ready", o_cmd_ready, 1);
        sb.push_back(-6);
        send_cmd(1);
        send_beat(pk(-2,0,0,0), pk(3,0,0,0), 1'b1, 1'b1);
        wait_empty();

        // ---- overflow with full FIFO
        i_res_ready = 1'b0;
        for (int k = 11; k <= 14; k++) begin
            sb.push_back(k);
            send_cmd(1);
            send_beat(pk(k,0,0,0), pk(1,0,0,0), 1'b1, 1'b1);
        end
        repeat (LAT + 6) tick();
        chk("ovf_before", o_err_overflow, 0);
        force_v = 1'b1;
        force_s = 12345;
        tick();
        force_v = 1'b0;
        chk("ovf_set", o_err_overflow, 1);
        repeat (5) tick();
        chk("ovf_held", o_err_overflow, 1);
        chk("ovf_head_unchanged", $signed(o_res_sum), 11);
        i_res_ready = 1'b1;
        wait_empty();
        repeat (3) tick();
        chk("ovf_no_extra", o_res_valid, 0);
        chk("ovf_sticky", o_err_overflow, 1);
        chk("ovf_busy_falls", o_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1);
    end

endmodule
